// File: rtl/hex_counter_display.sv
// Debounced push-button up/down counter. The count is shown on a time-multiplexed
// N-digit hex 7-segment display and mirrored on the LEDs.
module hex_counter_display #(
  parameter int WIDTH           = 16,
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SCAN_DIV        = 1000,
  parameter bit SEG_ACTIVE_LOW  = 1'b0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key,
  input  logic              dir,
  input  logic              clr,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  leds,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_en,
  output logic              press
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int SDW = $clog2(SCAN_DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic             key_meta_r, key_sync_r, dir_meta_r, dir_sync_r;
  logic [DBW-1:0]   db_cnt_r, db_cnt_nxt_s;
  logic             key_db_r, key_db_nxt_s, key_db_d_r;
  logic             rise_s, press_r;
  logic [WIDTH-1:0] count_r, count_nxt_s;
  logic [SDW-1:0]   div_r, div_nxt_s;
  logic             tick_s;
  logic [IW-1:0]    idx_r, idx_nxt_s;
  logic [WIDTH+3:0] ext_s, shifted_s;
  logic [3:0]       nib_s;
  logic [6:0]       seg_r;
  logic [DIGITS-1:0] digit_en_r, digit_en_nxt_s;

  // Debounce: the filtered key only follows the synchronised key after a full stable run
  always_comb begin
    db_cnt_nxt_s = db_cnt_r;
    key_db_nxt_s = key_db_r;
    if (key_sync_r != key_db_r) begin
      if (db_cnt_r == DBW'(DEBOUNCE_CYCLES - 1)) begin
        key_db_nxt_s = key_sync_r;
        db_cnt_nxt_s = '0;
      end else begin
        db_cnt_nxt_s = db_cnt_r + DBW'(1);
      end
    end else begin
      db_cnt_nxt_s = '0;
    end
  end

  assign rise_s = key_db_r & ~key_db_d_r;

  // Counter next value: clear wins over a simultaneous press
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = '0;
    end else if (rise_s) begin
      if (dir_sync_r) begin
        count_nxt_s = count_r - WIDTH'(1);
      end else begin
        count_nxt_s = count_r + WIDTH'(1);
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Scan divider, digit index and the nibble of the digit about to be shown
  always_comb begin
    tick_s = (div_r == SDW'(SCAN_DIV - 1));
    div_nxt_s = div_r + SDW'(1);
    idx_nxt_s = idx_r;
    if (tick_s) begin
      div_nxt_s = '0;
      if (idx_r == IW'(DIGITS - 1)) begin
        idx_nxt_s = '0;
      end else begin
        idx_nxt_s = idx_r + IW'(1);
      end
    end else begin
      idx_nxt_s = idx_r;
    end
    ext_s          = {4'b0000, count_r};
    shifted_s      = ext_s >> (32'd4 * 32'(idx_nxt_s));
    nib_s          = shifted_s[3:0];
    digit_en_nxt_s = DIGITS'(1'b1) << idx_nxt_s;
  end

  // Input synchronisers, debounce state and press edge detect
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta_r <= 1'b0;
      key_sync_r <= 1'b0;
      dir_meta_r <= 1'b0;
      dir_sync_r <= 1'b0;
      db_cnt_r   <= '0;
      key_db_r   <= 1'b0;
      key_db_d_r <= 1'b0;
      press_r    <= 1'b0;
    end else begin
      key_meta_r <= key;
      key_sync_r <= key_meta_r;
      dir_meta_r <= dir;
      dir_sync_r <= dir_meta_r;
      db_cnt_r   <= db_cnt_nxt_s;
      key_db_r   <= key_db_nxt_s;
      key_db_d_r <= key_db_r;
      press_r    <= rise_s;
    end
  end

  // Event counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  // Display scan; seg and digit_en load together so a slot never shows a mixed state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_r      <= '0;
      idx_r      <= '0;
      seg_r      <= 7'h00;
      digit_en_r <= '0;
    end else begin
      div_r <= div_nxt_s;
      idx_r <= idx_nxt_s;
      if (tick_s) begin
        seg_r      <= hex_decode(nib_s);
        digit_en_r <= digit_en_nxt_s;
      end else begin
        seg_r      <= seg_r;
        digit_en_r <= digit_en_r;
      end
    end
  end

  assign count    = count_r;
  assign leds     = count_r;
  assign press    = press_r;
  assign seg      = seg_r ^ {7{SEG_ACTIVE_LOW}};
  assign digit_en = digit_en_r ^ {DIGITS{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_hex_counter_display.sv
// Scoreboard bench: three display variants share one key/dir/clr stimulus; expected
// press and scan-slot responses are queued by the stimulus and popped by monitors.
module tb_hex_counter_display;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key = 1'b0, dir = 1'b0, clr = 1'b0;
  logic [7:0] count_a, leds_a, count_b, leds_b;
  logic [5:0] count_c, leds_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] en_a, en_b;
  logic [2:0] en_c;
  logic       press_a, press_b, press_c;
  logic [1:0] prev_en_a;
  logic [2:0] prev_en_c;

  int n_vec = 0;
  int n_err = 0;
  int edges;

  typedef struct {logic [7:0] cnt_a; logic [5:0] cnt_c; int edge_no;} press_t;
  typedef struct {logic [1:0] en_a; logic [6:0] seg_a; logic [1:0] en_b; logic [6:0] seg_b;} scan_t;
  typedef struct {logic [2:0] en; logic [6:0] seg;} scanc_t;

  press_t press_q[$];
  scan_t  scan_q[$];
  scanc_t scanc_q[$];

  hex_counter_display #(.WIDTH(8), .DIGITS(2), .DEBOUNCE_CYCLES(4), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key), .dir(dir), .clr(clr),
    .count(count_a), .leds(leds_a), .seg(seg_a), .digit_en(en_a), .press(press_a));

  hex_counter_display #(.WIDTH(8), .DIGITS(2), .DEBOUNCE_CYCLES(4), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key), .dir(dir), .clr(clr),
    .count(count_b), .leds(leds_b), .seg(seg_b), .digit_en(en_b), .press(press_b));

  hex_counter_display #(.WIDTH(6), .DIGITS(3), .DEBOUNCE_CYCLES(4), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b0)) dut_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key), .dir(dir), .clr(clr),
    .count(count_c), .leds(leds_c), .seg(seg_c), .digit_en(en_c), .press(press_c));

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) edges <= 0;
    else            edges <= edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Press monitor: every press pulse must match the next queued expectation
  always @(negedge sys_clk) begin
    if (sys_rst_n && press_a) begin
      if (press_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_press: got press with count %0h, expected none (t=%0t)", count_a, $time);
      end else begin
        press_t e;
        e = press_q.pop_front();
        chk("press_count", count_a, e.cnt_a);
        chk("press_leds", leds_a, e.cnt_a);
        chk("press_count_b", count_b, e.cnt_a);
        chk("press_count_c", count_c, e.cnt_c);
        chk("press_leds_c", leds_c, e.cnt_c);
        chk("press_b", press_b, press_a);
        chk("press_c", press_c, press_a);
        chk("press_edge", edges, e.edge_no);
      end
    end
  end

  // Scan monitors: pop on each digit change while expectations are pending
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_en_a <= 2'b00;
      prev_en_c <= 3'b000;
    end else begin
      if (en_a != prev_en_a && scan_q.size() > 0) begin
        scan_t s;
        s = scan_q.pop_front();
        chk("scan_en_a", en_a, s.en_a);
        chk("scan_seg_a", seg_a, s.seg_a);
        chk("scan_en_b", en_b, s.en_b);
        chk("scan_seg_b", seg_b, s.seg_b);
        chk("scan_slot_edge", edges % 3, 0);
      end
      if (en_c != prev_en_c && scanc_q.size() > 0) begin
        scanc_t s;
        s = scanc_q.pop_front();
        chk("scan_en_c", en_c, s.en);
        chk("scan_seg_c", seg_c, s.seg);
      end
      prev_en_a <= en_a;
      prev_en_c <= en_c;
    end
  end

  task automatic do_press(input int hi, input int lo, input logic [7:0] ea,
                          input logic [5:0] ec, input bit expect_ev);
    @(posedge sys_clk); #1;
    if (expect_ev) press_q.push_back('{ea, ec, edges + 7});
    key = 1'b1;
    repeat (hi) @(posedge sys_clk);
    #1 key = 1'b0;
    repeat (lo) @(posedge sys_clk);
  endtask

  task automatic clear_pulse();
    @(posedge sys_clk); #1 clr = 1'b1;
    @(posedge sys_clk); #1 clr = 1'b0;
    chk("clr_count", count_a, 8'h00);
  endtask

  // Wait until the bench's own edge count since reset sits at a known scan phase
  task automatic align(input int m, input int r);
    int guard;
    guard = 0;
    do begin
      @(posedge sys_clk); #1;
      guard++;
    end while ((edges % m) != r && guard < 50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_count", count_a, 8'h00);
    chk("rst_leds", leds_a, 8'h00);
    chk("rst_press", press_a, 1'b0);
    chk("rst_en_a", en_a, 2'b00);
    chk("rst_seg_a", seg_a, 7'h00);
    chk("rst_en_b", en_b, 2'b11);
    chk("rst_seg_b", seg_b, 7'h7F);
    chk("rst_en_c", en_c, 3'b000);
    @(negedge sys_clk) sys_rst_n = 1'b1;

    // One long press: single pulse, count 0 -> 1, release is silent
    do_press(20, 20, 8'h01, 6'h01, 1'b1);

    // Short glitch is rejected, five-cycle press is accepted
    clear_pulse();
    do_press(3, 12, 8'h00, 6'h00, 1'b0);
    chk("glitch_count", count_a, 8'h00);
    do_press(5, 12, 8'h01, 6'h01, 1'b1);

    // Down from 0 wraps to all-ones, then check the 6-bit/3-digit display
    clear_pulse();
    dir = 1'b1;
    repeat (4) @(posedge sys_clk);
    do_press(6, 10, 8'hFF, 6'h3F, 1'b1);
    align(9, 7);
    scanc_q.push_back('{3'b001, 7'h71});
    scanc_q.push_back('{3'b010, 7'h4F});
    scanc_q.push_back('{3'b100, 7'h3F});
    repeat (14) @(posedge sys_clk);

    // Up from all-ones wraps to 0
    dir = 1'b0;
    repeat (4) @(posedge sys_clk);
    do_press(6, 10, 8'h00, 6'h00, 1'b1);

    // Count up to 0xA5 and check both polarities of the display
    for (int i = 1; i <= 165; i++) do_press(6, 8, 8'(i), 6'(i), 1'b1);
    align(6, 4);
    scan_q.push_back('{2'b01, 7'h6D, 2'b10, 7'h12});
    scan_q.push_back('{2'b10, 7'h77, 2'b01, 7'h08});
    scan_q.push_back('{2'b01, 7'h6D, 2'b10, 7'h12});
    scan_q.push_back('{2'b10, 7'h77, 2'b01, 7'h08});
    repeat (14) @(posedge sys_clk);

    // Clear held across the press: the press pulses but the count stays 0
    @(posedge sys_clk); #1;
    press_q.push_back('{8'h00, 6'h00, edges + 7});
    key = 1'b1;
    clr = 1'b1;
    repeat (9) @(posedge sys_clk);
    #1;
    chk("clr_press_count", count_a, 8'h00);
    key = 1'b0;
    clr = 1'b0;
    repeat (10) @(posedge sys_clk);

    // Reset mid-debounce clears everything at once; no press follows with key low
    do_press(6, 10, 8'h01, 6'h01, 1'b1);
    @(posedge sys_clk); #1 key = 1'b1;
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_count", count_a, 8'h00);
    chk("async_rst_leds", leds_a, 8'h00);
    chk("async_rst_en", en_a, 2'b00);
    chk("async_rst_press", press_a, 1'b0);
    key = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1 chk("post_rst_count", count_a, 8'h00);

    // Key held through reset release is accepted once debounced
    #2 sys_rst_n = 1'b0;
    key = 1'b1;
    press_q.push_back('{8'h01, 6'h01, 7});
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (12) @(posedge sys_clk);
    #1 key = 1'b0;
    repeat (12) @(posedge sys_clk);

    #1;
    chk("press_q_drained", press_q.size(), 0);
    chk("scan_q_drained", scan_q.size(), 0);
    chk("scanc_q_drained", scanc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
